// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants and helpers for the multi-port register file.
//   XLEN_DEF / NREGS_DEF / NRD_DEF / NWR_DEF : default configuration
//   ZERO_REG                                 : hard-wired zero register index
//   addr_width()                             : register address width for a given count
package regfile_pkg;

  localparam int XLEN_DEF  = 64;
  localparam int NREGS_DEF = 32;
  localparam int NRD_DEF   = 2;
  localparam int NWR_DEF   = 2;
  localparam int ZERO_REG  = 0;

  function automatic int addr_width(input int nregs);
    return $clog2(nregs);
  endfunction

endpackage

// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter: folds NWR write ports into one write enable and one
// write-data word per register. When several ports target the same register,
// the highest-index port wins. Writes to the zero register are dropped.
//   wr_en    in  NWR          per-port write enable
//   wr_addr  in  NWR*AW       per-port write address
//   wr_data  in  NWR*XLEN     per-port write data
//   sel_we   out NREGS        register is written this cycle
//   sel_data out [NREGS] XLEN data selected for each written register
module regfile_wr_arbiter
  import regfile_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int NWR   = NWR_DEF,
  parameter int AW    = addr_width(NREGS)
) (
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  output logic [NREGS-1:0]    sel_we,
  output logic [XLEN-1:0]     sel_data [NREGS]
);

  logic [AW-1:0] addr;

  // Ascending port order: later (higher-index) ports overwrite earlier ones.
  always_comb begin
    sel_we = '0;
    addr   = '0;
    for (int unsigned r = 0; r < NREGS; r++) sel_data[r] = '0;
    for (int unsigned p = 0; p < NWR; p++) begin
      addr = wr_addr[p*AW +: AW];
      if (wr_en[p] && addr != AW'(ZERO_REG)) begin
        sel_we[addr]   = 1'b1;
        sel_data[addr] = wr_data[p*XLEN +: XLEN];
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port integer register file with per-register busy
// scoreboard for RAW hazard detection. x0 reads as zero and is never busy.
//   clk, rst  clock (rising edge), asynchronous active-high reset
//   rd_addr   in  NRD*AW      read addresses
//   rd_data   out NRD*XLEN    combinational read data
//   rd_busy   out NRD         addressed register has a pending producer
//   wr_en     in  NWR         per-port write enable
//   wr_addr   in  NWR*AW      write addresses
//   wr_data   in  NWR*XLEN    write data
//   rsv_en    in  1           reserve (mark busy) request
//   rsv_addr  in  AW          register claimed by the issuing instruction
//   busy_cnt  out AW+1        registered count of busy registers
// Build option: define REGFILE_BYPASS_EN to forward same-cycle write data
// (and the resulting busy state) to the read ports.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int NRD   = NRD_DEF,
  parameter int NWR   = NWR_DEF,
  localparam int AW   = addr_width(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic                rsv_en,
  input  logic [AW-1:0]       rsv_addr,
  output logic [AW:0]         busy_cnt
);

  logic [XLEN-1:0]  mem [NREGS];
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_nxt;
  logic [AW:0]      cnt_nxt;
  logic [NREGS-1:0] sel_we;
  logic [XLEN-1:0]  sel_data [NREGS];
  logic             rsv_hit;

  assign rsv_hit = rsv_en && (rsv_addr != AW'(ZERO_REG));

  regfile_wr_arbiter #(
    .XLEN  (XLEN),
    .NREGS (NREGS),
    .NWR   (NWR),
    .AW    (AW)
  ) u_arb (
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .sel_we   (sel_we),
    .sel_data (sel_data)
  );

  // Completing writes release their register; a same-cycle reserve of the
  // same register is applied afterwards so the new producer keeps it busy.
  always_comb begin
    busy_nxt = busy & ~sel_we;
    if (rsv_hit) busy_nxt[rsv_addr] = 1'b1;
    busy_nxt[ZERO_REG] = 1'b0;
  end

  always_comb begin
    cnt_nxt = '0;
    for (int unsigned i = 0; i < NREGS; i++)
      cnt_nxt = cnt_nxt + {{AW{1'b0}}, busy_nxt[i]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned r = 0; r < NREGS; r++) mem[r] <= '0;
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      for (int unsigned r = 0; r < NREGS; r++)
        if (sel_we[r]) mem[r] <= sel_data[r];
      busy     <= busy_nxt;
      busy_cnt <= cnt_nxt;
    end
  end

  always_comb begin
    logic [AW-1:0]   a;
    logic [XLEN-1:0] d;
    logic            b;
    rd_data = '0;
    rd_busy = '0;
    for (int unsigned k = 0; k < NRD; k++) begin
      a = rd_addr[k*AW +: AW];
      d = mem[a];
      b = busy[a];
`ifdef REGFILE_BYPASS_EN
      // Forwarded register is busy only if a new producer claims it now.
      if (!rst && sel_we[a]) begin
        d = sel_data[a];
        b = rsv_hit && (rsv_addr == a);
      end
`else
      if (rst) begin
        d = '0;
        b = 1'b0;
      end
`endif
      if (a == AW'(ZERO_REG)) begin
        d = '0;
        b = 1'b0;
      end
      rd_data[k*XLEN +: XLEN] = d;
      rd_busy[k]              = b;
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed self-checking bench for regfile_mp (default
// configuration: XLEN=64, NREGS=32, NRD=2, NWR=2).
module tb_regfile_mp;

  localparam int XLEN = 64;
  localparam int AW   = 5;
  localparam int NRD  = 2;
  localparam int NWR  = 2;

  logic                clk;
  logic                rst;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic [NWR-1:0]      wr_en;
  logic [NWR*AW-1:0]   wr_addr;
  logic [NWR*XLEN-1:0] wr_data;
  logic                rsv_en;
  logic [AW-1:0]       rsv_addr;
  logic [AW:0]         busy_cnt;

  int checks = 0;
  int errors = 0;

  regfile_mp #(
    .XLEN  (XLEN),
    .NREGS (32),
    .NRD   (NRD),
    .NWR   (NWR)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_busy  (rd_busy),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .busy_cnt (busy_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en    = '0;
    wr_addr  = '0;
    wr_data  = '0;
    rsv_en   = 1'b0;
    rsv_addr = '0;
  endtask

  task automatic set_rd(input int k, input int a);
    rd_addr[k*AW +: AW] = AW'(a);
  endtask

  task automatic set_wr(input int p, input int a, input logic [63:0] d);
    wr_en[p]                = 1'b1;
    wr_addr[p*AW +: AW]     = AW'(a);
    wr_data[p*XLEN +: XLEN] = d;
  endtask

  task automatic reserve(input int a);
    rsv_en   = 1'b1;
    rsv_addr = AW'(a);
  endtask

  function automatic logic [63:0] rdd(input int k);
    return rd_data[k*XLEN +: XLEN];
  endfunction

  initial begin
    idle();
    rd_addr = '0;
    rst     = 1'b1;
    repeat (2) tick();
    set_rd(0, 5);
    set_rd(1, 6);
    #1;
    check("reset_rd0", rdd(0), 64'h0);
    check("reset_busy", 64'(rd_busy), 64'h0);
    check("reset_cnt", 64'(busy_cnt), 64'h0);
    rst = 1'b0;

    // x5 = 0xDEAD, reserve x6, then async reset mid-cycle
    tick();
    set_wr(0, 5, 64'hDEAD);
    reserve(6);
    tick();
    idle();
    #1;
    check("pre_rst_x5", rdd(0), 64'hDEAD);
    check("pre_rst_busy6", 64'(rd_busy[1]), 64'h1);
    check("pre_rst_cnt", 64'(busy_cnt), 64'h1);
    #1 rst = 1'b1;
    #1;
    check("rst_async_x5", rdd(0), 64'h0);
    check("rst_async_busy", 64'(rd_busy), 64'h0);
    check("rst_async_cnt", 64'(busy_cnt), 64'h0);
    tick();
    rst = 1'b0;
    tick();
    check("rst_rel_x5", rdd(0), 64'h0);
    check("rst_rel_busy", 64'(rd_busy), 64'h0);
    check("rst_rel_cnt", 64'(busy_cnt), 64'h0);

    // x0 write and reserve are ignored
    set_wr(0, 0, 64'hFFFF);
    reserve(0);
    set_rd(0, 0);
    tick();
    idle();
    #1;
    check("x0_data", rdd(0), 64'h0);
    check("x0_busy", 64'(rd_busy[0]), 64'h0);
    check("x0_cnt", 64'(busy_cnt), 64'h0);

    // Same-address write conflict: port 1 wins
    set_wr(0, 7, 64'h11);
    set_wr(1, 7, 64'h22);
    tick();
    idle();
    set_rd(0, 7);
    #1;
    check("conflict_x7", rdd(0), 64'h22);
    check("conflict_busy", 64'(rd_busy[0]), 64'h0);

    // Scoreboard on x3
    reserve(3);
    set_rd(0, 3);
    tick();
    idle();
    #1;
    check("rsv_busy3", 64'(rd_busy[0]), 64'h1);
    check("rsv_cnt", 64'(busy_cnt), 64'h1);
    set_wr(1, 3, 64'h55);
    tick();
    idle();
    #1;
    check("rel_busy3", 64'(rd_busy[0]), 64'h0);
    check("rel_cnt", 64'(busy_cnt), 64'h0);
    check("rel_data3", rdd(0), 64'h55);
    set_wr(0, 3, 64'h77);
    reserve(3);
    tick();
    idle();
    #1;
    check("rsvwr_busy3", 64'(rd_busy[0]), 64'h1);
    check("rsvwr_cnt", 64'(busy_cnt), 64'h1);
    check("rsvwr_data3", rdd(0), 64'h77);

    // Write x9 while reading it
    set_rd(1, 9);
    set_wr(1, 9, 64'hABCD);
    #1;
`ifdef REGFILE_BYPASS_EN
    check("byp_same_x9", rdd(1), 64'hABCD);
`else
    check("byp_same_x9", rdd(1), 64'h0);
`endif
    check("byp_same_busy9", 64'(rd_busy[1]), 64'h0);
    tick();
    idle();
    #1;
    check("byp_next_x9", rdd(1), 64'hABCD);

    // Saturation: reserve x1..x31 (x3 already busy)
    for (int i = 1; i < 32; i++) begin
      reserve(i);
      tick();
    end
    idle();
    set_rd(1, 31);
    #1;
    check("sat_cnt", 64'(busy_cnt), 64'd31);
    check("sat_busy31", 64'(rd_busy[1]), 64'h1);
    check("sat_busy3", 64'(rd_busy[0]), 64'h1);

    // Release two per cycle
    for (int i = 1; i < 32; i += 2) begin
      idle();
      set_wr(0, i, 64'(i));
      if (i + 1 < 32) set_wr(1, i + 1, 64'(i + 1));
      tick();
      if (i == 1) check("rel_partial_cnt", 64'(busy_cnt), 64'd29);
    end
    idle();
    #1;
    check("unsat_cnt", 64'(busy_cnt), 64'd0);
    check("unsat_busy31", 64'(rd_busy[1]), 64'h0);
    check("unsat_x31", rdd(1), 64'd31);
    check("unsat_x3", rdd(0), 64'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port integer register file with a per-register scoreboard, the next generation of the CPU register file for the pipelined datapath. It provides NRD asynchronous read ports and NWR clocked write ports, keeps x0 hard-wired to zero, and tracks which registers have an in-flight producer so decode can stall on RAW hazards. Optional write-to-read bypass lets a read return data being written in the same cycle.

## Interface
- XLEN, 64, data width in bits
- NREGS, 32, register count; power of two, ≥2; AW = $clog2(NREGS)
- NRD, 2, read port count, ≥1
- NWR, 2, write port count, ≥1
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- rd_addr  in  NRD*AW  read addresses; port k at [k*AW +: AW]
- rd_data  out  NRD*XLEN  read data, port k at [k*XLEN +: XLEN]
- rd_busy  out  NRD  1 = register addressed by port k has a pending producer
- wr_en  in  NWR  per-port write enable
- wr_addr  in  NWR*AW  write addresses
- wr_data  in  NWR*XLEN  write data
- rsv_en  in  1  reserve request; marks rsv_addr busy
- rsv_addr  in  AW  register being claimed by a newly issued instruction
- busy_cnt  out  AW+1  number of registers currently busy

## Operation
- Storage: NREGS x XLEN array plus NREGS busy bits; x0 never written, never busy.
- Read: rd_data[k] = reg[rd_addr[k]] combinationally; address 0 always returns 0; rd_busy[k] = busy[rd_addr[k]] (0 for x0).
- Write: at posedge, each port with wr_en=1 and wr_addr≠0 writes wr_data into reg[wr_addr] and clears busy[wr_addr].
- Write conflict: several ports writing the same address in one cycle → highest-index port wins; busy cleared once.
- Reserve: at posedge, rsv_en=1 and rsv_addr≠0 sets busy[rsv_addr]. Reserve of an already-busy register is legal (stays busy).
- Reserve and write to same register in the same cycle: reserve wins, busy ends 1 (new producer supersedes the completing one); data is still written.
- Write to a non-busy register: data written, busy stays 0.
- busy_cnt: registered population count of busy bits, updated at the same edge as busy; range 0..NREGS-1.
- Reset: all registers 0, all busy bits 0, busy_cnt 0; rd_data = 0 and rd_busy = 0 while rst high and after release. Reset asserted mid-cycle overrides any pending write/reserve.

## Timing
- Read latency: 0 cycles (combinational from rd_addr and array state).
- Write latency: data visible on rd_data the cycle after the write edge (without bypass).
- rd_busy reflects a reserve or release one edge after it is presented; busy_cnt likewise.
- No handshake; write and reserve ports are fire-and-forget, one operation per port per cycle.

## Configuration
- REGFILE_BYPASS_EN defined: rd_data[k] returns wr_data of the highest-index port with wr_en=1 and wr_addr=rd_addr[k]≠0 in the same cycle, and rd_busy[k] is 0 for that register unless rsv_en targets it in the same cycle. Read becomes combinational from wr_* as well.
- Undefined: no bypass; reads see array contents only; same-cycle write is visible next cycle.

## Structure
- Shared package regfile_pkg: default XLEN/NREGS/NRD/NWR constants, ZERO_REG = 0, helper function for AW.
- One sub-module: regfile_wr_arbiter, resolves per-register write-enable and selected write data across NWR ports (highest index wins), reused by both array update and bypass path.
- Top holds array, busy vector, popcount register and read muxes.

## Test plan
- Reset: write x5=0xDEAD, assert rst asynchronously mid-cycle → all rd_data 0, rd_busy 0, busy_cnt 0 immediately and after release.
- x0: wr_en port0 addr 0 data 0xFFFF, rsv_en addr 0 → rd_data from addr 0 is 0, rd_busy 0, busy_cnt 0.
- Conflict: port0 and port1 both write x7 (0x11, 0x22) → next cycle read x7 = 0x22.
- Scoreboard: reserve x3 → rd_busy=1, busy_cnt=1; write x3=0x55 → rd_busy=0, busy_cnt=0, data 0x55; same-cycle reserve+write x3 → busy stays 1, data written.
- Bypass: write x9=0xABCD while reading x9 → with REGFILE_BYPASS_EN rd_data=0xABCD same cycle; without, old value then 0xABCD next cycle.
- Saturation: reserve x1..x31 over 31 cycles → busy_cnt=31; release all via NWR ports → busy_cnt back to 0.
